// File: rtl/morse_encoder.sv
// Serial Morse encoder: one ASCII character in, timed dot/dash/letter-gap/word-gap strobes out.
// Optional build macro MORSE_LOWERCASE_EN maps a-z onto A-Z.
//
// state | meaning
// IDLE  | waiting for a character, din_ready high
// SYM   | a dot or dash strobe is on the outputs this cycle
// GAP   | inter-symbol silence, GAP_CYCLES cycles after every symbol
// LGAP  | letter-gap strobe on the outputs, character complete
// WGAP  | word-gap strobe on the outputs (ASCII space)
// ERR   | error strobe on the outputs (unsupported character)
module morse_encoder #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dot,
    output logic       dash,
    output logic       lg,
    output logic       wg,
    output logic       busy,
    output logic       error
);

    typedef enum logic [2:0] {IDLE, SYM, GAP, LGAP, WGAP, ERR} state_t;

    localparam logic [4:0] S_DOT  = 5'b10000;
    localparam logic [4:0] S_DASH = 5'b01000;
    localparam logic [4:0] S_LG   = 5'b00100;
    localparam logic [4:0] S_WG   = 5'b00010;
    localparam logic [4:0] S_ERR  = 5'b00001;

    localparam bit         NO_GAP   = (GAP_CYCLES == 0);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     state, state_n;
    logic [4:0] strb_q, strb_n;
    logic       busy_q;
    logic [4:0] pat_q, pat_n;
    logic [2:0] rem_q, rem_n;
    logic [3:0] gap_q, gap_n;
    logic       advance;
    logic       accept;
    logic [8:0] lk;
    logic [4:0] aligned;

    // Returns {supported, length[2:0], pattern[4:0]}; pattern right-aligned, MSB first, 1 = dash.
    function automatic logic [8:0] lookup(input logic [7:0] c);
        logic [7:0] u;
        u = c;
`ifdef MORSE_LOWERCASE_EN
        if (c >= 8'd97 && c <= 8'd122) u = c - 8'd32;
`endif
        case (u)
            8'd65: lookup = {1'b1, 3'd2, 5'b00001}; // A
            8'd66: lookup = {1'b1, 3'd4, 5'b01000}; // B
            8'd67: lookup = {1'b1, 3'd4, 5'b01010}; // C
            8'd68: lookup = {1'b1, 3'd3, 5'b00100}; // D
            8'd69: lookup = {1'b1, 3'd1, 5'b00000}; // E
            8'd70: lookup = {1'b1, 3'd4, 5'b00010}; // F
            8'd71: lookup = {1'b1, 3'd3, 5'b00110}; // G
            8'd72: lookup = {1'b1, 3'd4, 5'b00000}; // H
            8'd73: lookup = {1'b1, 3'd2, 5'b00000}; // I
            8'd74: lookup = {1'b1, 3'd4, 5'b00111}; // J
            8'd75: lookup = {1'b1, 3'd3, 5'b00101}; // K
            8'd76: lookup = {1'b1, 3'd4, 5'b00100}; // L
            8'd77: lookup = {1'b1, 3'd2, 5'b00011}; // M
            8'd78: lookup = {1'b1, 3'd2, 5'b00010}; // N
            8'd79: lookup = {1'b1, 3'd3, 5'b00111}; // O
            8'd80: lookup = {1'b1, 3'd4, 5'b00110}; // P
            8'd81: lookup = {1'b1, 3'd4, 5'b01101}; // Q
            8'd82: lookup = {1'b1, 3'd3, 5'b00010}; // R
            8'd83: lookup = {1'b1, 3'd3, 5'b00000}; // S
            8'd84: lookup = {1'b1, 3'd1, 5'b00001}; // T
            8'd85: lookup = {1'b1, 3'd3, 5'b00001}; // U
            8'd86: lookup = {1'b1, 3'd4, 5'b00001}; // V
            8'd87: lookup = {1'b1, 3'd3, 5'b00011}; // W
            8'd88: lookup = {1'b1, 3'd4, 5'b01001}; // X
            8'd89: lookup = {1'b1, 3'd4, 5'b01011}; // Y
            8'd90: lookup = {1'b1, 3'd4, 5'b01100}; // Z
            8'd48: lookup = {1'b1, 3'd5, 5'b11111}; // 0
            8'd49: lookup = {1'b1, 3'd5, 5'b01111}; // 1
            8'd50: lookup = {1'b1, 3'd5, 5'b00111}; // 2
            8'd51: lookup = {1'b1, 3'd5, 5'b00011}; // 3
            8'd52: lookup = {1'b1, 3'd5, 5'b00001}; // 4
            8'd53: lookup = {1'b1, 3'd5, 5'b00000}; // 5
            8'd54: lookup = {1'b1, 3'd5, 5'b10000}; // 6
            8'd55: lookup = {1'b1, 3'd5, 5'b11000}; // 7
            8'd56: lookup = {1'b1, 3'd5, 5'b11100}; // 8
            8'd57: lookup = {1'b1, 3'd5, 5'b11110}; // 9
            8'd61: lookup = {1'b1, 3'd5, 5'b10001}; // =
            default: lookup = 9'd0;
        endcase
    endfunction

    assign din_ready = (state == IDLE) && !rst;
    assign accept    = din_valid && din_ready;
    assign {dot, dash, lg, wg, error} = strb_q;
    assign busy = busy_q;

    always_comb begin
        state_n = state;
        strb_n  = '0;
        pat_n   = pat_q;
        rem_n   = rem_q;
        gap_n   = gap_q;
        advance = 1'b0;
        lk      = lookup(din);
        aligned = lk[4:0] << (3'd5 - lk[7:5]);

        case (state)
            IDLE: begin
                if (accept) begin
                    if (lk[8]) begin
                        // First symbol leaves straight from the accept edge; the rest are shifted out of pat_q.
                        strb_n  = aligned[4] ? S_DASH : S_DOT;
                        pat_n   = {aligned[3:0], 1'b0};
                        rem_n   = lk[7:5] - 3'd1;
                        state_n = SYM;
                    end else if (din == 8'd32) begin
                        strb_n  = S_WG;
                        state_n = WGAP;
                    end else begin
                        strb_n  = S_ERR;
                        state_n = ERR;
                    end
                end
            end
            SYM: begin
                if (NO_GAP) begin
                    advance = 1'b1;
                end else begin
                    gap_n   = GAP_LOAD;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) advance = 1'b1;
                else               gap_n = gap_q - 4'd1;
            end
            default: state_n = IDLE;
        endcase

        if (advance) begin
            if (rem_q != 3'd0) begin
                strb_n  = pat_q[4] ? S_DASH : S_DOT;
                pat_n   = {pat_q[3:0], 1'b0};
                rem_n   = rem_q - 3'd1;
                state_n = SYM;
            end else begin
                strb_n  = S_LG;
                state_n = LGAP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            strb_q <= '0;
            busy_q <= 1'b0;
            pat_q  <= '0;
            rem_q  <= '0;
            gap_q  <= '0;
        end else begin
            state  <= state_n;
            strb_q <= strb_n;
            busy_q <= (state_n != IDLE);
            pat_q  <= pat_n;
            rem_q  <= rem_n;
            gap_q  <= gap_n;
        end
    end

endmodule

// File: doc/morse_encoder.md
MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 SHALL have parameter: GAP_CYCLES, 1, idle cycles after each dot/dash strobe (legal 0..15).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: din  input  8  ASCII character to encode.
REQ-005 SHALL have port: din_valid  input  1  din holds a character.
REQ-006 SHALL have port: din_ready  output  1  encoder can accept a character.
REQ-007 SHALL have port: dot  output  1  one-cycle dot strobe.
REQ-008 SHALL have port: dash  output  1  one-cycle dash strobe.
REQ-009 SHALL have port: lg  output  1  one-cycle letter-gap strobe, ending a character.
REQ-010 SHALL have port: wg  output  1  one-cycle word-gap strobe, for ASCII space.
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port: error  output  1  one-cycle strobe for an unsupported character.

Function
REQ-013 SHALL use states IDLE, SYM, GAP, LGAP, WGAP, ERR.
REQ-014 SHALL drive din_ready = (state==IDLE) && !rst; a character is accepted on the edge where din_valid && din_ready.
REQ-015 SHALL register din on acceptance; later din changes SHALL have no effect until the next acceptance.
REQ-016 SHALL support ITU codes for A-Z (65-90), 0-9 (48-57) and '=' (61, -...-), 1 to 5 symbols, via an internal length[2:0]/pattern[4:0] table, MSB-first, 1 = dash.
REQ-017 Accept at cycle T of a supported character with n symbols: symbol k (0..n-1) SHALL strobe dot or dash in cycle T+1+k*(GAP_CYCLES+1).
REQ-018 The GAP state SHALL hold all strobes low for GAP_CYCLES cycles after every symbol, including the last.
REQ-019 lg SHALL strobe in cycle T+1+n*(GAP_CYCLES+1); din_ready SHALL be high in the following cycle.
REQ-020 ASCII space (32) SHALL strobe wg in cycle T+1; din_ready SHALL be high in T+2; no lg is emitted.
REQ-021 Any other character SHALL strobe error in cycle T+1, emit no dot/dash/lg/wg, and return to IDLE with din_ready high in T+2.
REQ-022 At most one of dot, dash, lg, wg, error SHALL be high in any cycle.
REQ-023 All strobes and busy SHALL be registered outputs.
REQ-024 With GAP_CYCLES=0, the GAP state SHALL be skipped and strobes SHALL occur on consecutive cycles.
REQ-025 When din_valid is held high, back-to-back characters SHALL be accepted with no extra idle cycle beyond REQ-019.

Reset
REQ-026 A cycle with rst high SHALL force: state IDLE, dot=dash=lg=wg=error=0, busy=0, symbol and gap counters 0.
REQ-027 rst high mid-character SHALL abort it; no lg or remaining symbols SHALL be emitted.
REQ-028 din_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.

Configuration
REQ-029 With macro MORSE_LOWERCASE_EN defined, a-z (97-122) SHALL encode identically to A-Z.
REQ-030 Without MORSE_LOWERCASE_EN, 97-122 SHALL be unsupported and handled per REQ-021.

Verification (GAP_CYCLES=1, accept at T)
REQ-031 Send 'A'(65) -> dot T+1, dash T+3, lg T+5, din_ready high T+6.
REQ-032 Send '5'(53) -> dot at T+1, T+3, T+5, T+7, T+9; lg T+11; no dash.
REQ-033 Send space(32) -> wg T+1 only, din_ready T+2; then send '#'(35) at T+2 -> error T+3, no other strobes.
REQ-034 Send 'e'(101) -> with MORSE_LOWERCASE_EN: dot T+1, lg T+3; without: error T+1 only.
REQ-035 Send '0'(48), assert rst in T+4 for one cycle -> all strobes 0 from T+5, no lg emitted, din_ready high T+5.
REQ-036 Hold din_valid with 'E' then 'T' -> dot T+1, lg T+3, second accept T+4, dash T+5, lg T+7.
